// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : shift_deserializer
// Description : Serial-to-parallel receiver. Assembles N-bit words from a
//               strobed bit stream, with Sync-based word alignment, and hands
//               each completed word to the consumer over a valid/ready
//               handshake. A sticky Overrun flag records dropped words.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_deserializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Enable,
    input  logic         Sin,
    input  logic         Sync,
    output logic [N-1:0] Dout,
    output logic         DoutValid,
    input  logic         DoutReady,
    output logic         Busy,
    output logic         Overrun,
    input  logic         ClearOverrun
);

    localparam int                 c_CNT_W = $clog2(N);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [N-1:0]         r_shift;
    logic [N-1:0]         w_shift_nxt;
    logic [N-1:0]         w_shifted;
    logic                 w_complete;
    logic [N-1:0]         r_dout;
    logic                 r_valid;
    logic                 r_overrun;

    // Shift direction; the shifted value doubles as the assembled word on
    // the completing strobe.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shift[N-2:0], Sin};
        end else begin : g_lsb_first
            assign w_shifted = {Sin, r_shift[N-1:1]};
        end
    endgenerate

    // Receive state, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic; nothing moves without an Enable strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        if (Enable) begin
            w_shift_nxt = w_shifted;
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt   = c_ONE;
                    w_state_nxt = ST_RECV;
                end
                ST_RECV: begin
                    if (Sync) begin
                        // Realign: this bit becomes bit 0 of a fresh word.
                        w_cnt_nxt = c_ONE;
                    end else if (r_cnt == c_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        w_complete  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output word holding register, handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete) begin
                if (!r_valid || DoutReady) begin
                    r_dout  <= w_shifted;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && DoutReady) begin
                r_valid <= 1'b0;
            end
            // A drop on the same edge as a clear keeps the flag set.
            if (w_complete && r_valid && !DoutReady) begin
                r_overrun <= 1'b1;
            end else if (ClearOverrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign Dout      = r_dout;
    assign DoutValid = r_valid;
    assign Overrun   = r_overrun;
    assign Busy      = (r_state == ST_RECV);

endmodule
`default_nettype wire
